// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button front end: clog2, hold-FSM encoding
// and default timing for a 100 MHz system clock.
package button_conditioner_pkg;

  function automatic int clog2(input int value);
    int      result;
    longint  span;
    result = 0;
    span   = 1;
    while (span < longint'(value)) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } hold_state_e;

  localparam int SYS_CLK_HZ             = 100_000_000;
  localparam int DEF_DEBOUNCE_CYCLES    = SYS_CLK_HZ / 200;  // 5 ms
  localparam int DEF_LONG_PRESS_CYCLES  = SYS_CLK_HZ;        // 1 s
  localparam int DEF_REPEAT_CYCLES      = SYS_CLK_HZ / 4;    // 250 ms

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, counter debouncer, edge strobes and
// long-press / auto-repeat hold FSM. All outputs registered.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES,
  parameter bit REPEAT_EN         = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o,
  output logic repeat_o
);

  localparam int DB_W     = clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = clog2(HOLD_MAX) + 1;

  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LP_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LP_SAT  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] RP_LAST = HOLD_W'(REPEAT_CYCLES - 1);

  logic              s1_q, s2_q;
  logic              level_q, level_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              rise, fall;
  hold_state_e       state_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              press_q, release_q, long_q, repeat_q;

  // Any sample matching the current level restarts the count.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (s2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      s1_q     <= sig_i;
      s2_q     <= s1_q;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // A falling level pre-empts everything, so no hold strobe lands on or after release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      press_q   <= rise;
      release_q <= fall;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      if (fall) begin
        state_q    <= IDLE;
        hold_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_q    <= HELD;
              hold_cnt_q <= '0;
            end
          end
          HELD: begin
            if (hold_cnt_q == LP_LAST) begin
              long_q <= 1'b1;
              if (REPEAT_EN) begin
                state_q    <= REPEATING;
                hold_cnt_q <= '0;
              end else begin
                hold_cnt_q <= LP_SAT;
              end
            end else if (hold_cnt_q != LP_SAT) begin
              hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
          end
          REPEATING: begin
            if (hold_cnt_q == RP_LAST) begin
              repeat_q   <= 1'b1;
              hold_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
          end
          default: begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_q;
  assign repeat_o     = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button conditioner; one independent button_channel per input.
// evt is the combinational OR of the registered press and repeat strobes.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_CH              = 5,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES,
  parameter bit REPEAT_EN         = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] sig_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_press_o,
  output logic [N_CH-1:0] repeat_o,
  output logic [N_CH-1:0] evt_o
);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
      .REPEAT_CYCLES     (REPEAT_CYCLES),
      .REPEAT_EN         (REPEAT_EN)
    ) u_channel (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .sig_i        (sig_i[ch]),
      .level_o      (level_o[ch]),
      .press_o      (press_o[ch]),
      .release_o    (release_o[ch]),
      .long_press_o (long_press_o[ch]),
      .repeat_o     (repeat_o[ch])
    );
  end

  assign evt_o = press_o | repeat_o;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (auto-repeat on/off) driven by the
// same inputs, checked every cycle against a sliding-window / elapsed-time model.
module tb_button_conditioner;

  localparam int N  = 2;
  localparam int DB = 4;
  localparam int LP = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sig;
  logic [N-1:0] a_level, a_press, a_release, a_long, a_repeat, a_evt;
  logic [N-1:0] b_level, b_press, b_release, b_long, b_repeat, b_evt;

  button_conditioner #(.N_CH(N), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP),
                       .REPEAT_CYCLES(RP), .REPEAT_EN(1'b1)) dut_rep (
    .clk_i(clk), .rst_i(rst), .sig_i(sig), .level_o(a_level), .press_o(a_press),
    .release_o(a_release), .long_press_o(a_long), .repeat_o(a_repeat), .evt_o(a_evt));

  button_conditioner #(.N_CH(N), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP),
                       .REPEAT_CYCLES(RP), .REPEAT_EN(1'b0)) dut_norep (
    .clk_i(clk), .rst_i(rst), .sig_i(sig), .level_o(b_level), .press_o(b_press),
    .release_o(b_release), .long_press_o(b_long), .repeat_o(b_repeat), .evt_o(b_evt));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: raw samples since reset, believed level, press edge index.
  bit hist[N][$];
  bit lvl[N];
  int tp[N];
  int ecnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      hist[c].delete();
      lvl[c] = 1'b0;
      tp[c]  = 0;
    end
    ecnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_level"}, a_level | b_level, 0);
    chk({tag, "_strobes"}, a_press | a_release | a_long | a_repeat | b_press | b_release | b_long | b_repeat, 0);
    chk({tag, "_evt"}, a_evt | b_evt, 0);
  endtask

  // Apply one cycle of input, advance the model one edge, compare all outputs.
  task automatic cycle(input logic [N-1:0] s);
    logic [N-1:0] xl, xp, xr, xlong, xrep;
    sig   = s;
    xl    = '0;
    xp    = '0;
    xr    = '0;
    xlong = '0;
    xrep  = '0;
    @(posedge clk);
    for (int c = 0; c < N; c++) begin
      bit tog;
      int idx;
      int held;
      hist[c].push_back(s[c]);
      // Level flips once the synchronised input (2 edges old) has differed from it for DB edges.
      tog = 1'b1;
      for (int k = 0; k < DB; k++) begin
        idx = ecnt - 2 - k;
        if (((idx < 0) ? 1'b0 : hist[c][idx]) == lvl[c]) tog = 1'b0;
      end
      if (tog) begin
        lvl[c] = ~lvl[c];
        if (lvl[c]) begin
          xp[c] = 1'b1;
          tp[c] = ecnt;
        end else begin
          xr[c] = 1'b1;
        end
      end
      held     = ecnt - tp[c];
      xl[c]    = lvl[c];
      xlong[c] = lvl[c] && (held == LP);
      xrep[c]  = lvl[c] && (held > LP) && (((held - LP) % RP) == 0);
    end
    ecnt++;
    #1;
    chk("level",      a_level,   xl);
    chk("press",      a_press,   xp);
    chk("release",    a_release, xr);
    chk("long_press", a_long,    xlong);
    chk("repeat",     a_repeat,  xrep);
    chk("evt",        a_evt,     xp | xrep);
    chk("norep_level", b_level,  xl);
    chk("norep_long",  b_long,   xlong);
    chk("norep_repeat", b_repeat, '0);
    chk("norep_evt",   b_evt,    xp);
    @(negedge clk);
  endtask

  task automatic hold_for(input logic [N-1:0] s, input int n);
    for (int i = 0; i < n; i++) cycle(s);
  endtask

  initial begin
    logic [N-1:0] s;
    int remain[N];

    rst = 1'b1;
    sig = '0;
    model_reset();
    #3;
    check_all_zero("reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Clean press, long hold with repeats, clean release.
    hold_for(2'b01, 30);
    hold_for(2'b00, 10);

    // Bouncy press and bouncy release.
    cycle(2'b01); cycle(2'b00); cycle(2'b01); cycle(2'b00);
    hold_for(2'b01, 12);
    cycle(2'b00); cycle(2'b01); cycle(2'b00); cycle(2'b01);
    hold_for(2'b00, 10);

    // Release around the long-press boundary (level falls at press+h).
    for (int h = 7; h <= 12; h++) begin
      hold_for(2'b01, h);
      hold_for(2'b00, 10);
    end

    // Channel 1 alone, held past long press without repeat interference on ch0.
    hold_for(2'b10, 24);
    hold_for(2'b00, 8);

    // Randomised independent activity on both channels.
    s = '0;
    for (int c = 0; c < N; c++) remain[c] = 0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N; c++) begin
        if (remain[c] == 0) begin
          s[c]      = ~s[c];
          remain[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                  : int'($urandom_range(4, 28));
        end else begin
          remain[c]--;
        end
      end
      cycle(s);
    end
    hold_for(2'b00, 10);

    // Asynchronous reset in the middle of auto-repeat, input still held.
    hold_for(2'b01, 20);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid");
    @(posedge clk);
    #1;
    check_all_zero("reset_held");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    hold_for(2'b01, 20);
    hold_for(2'b00, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
